// File: rtl/alu_operand_b_pipe.sv
// Registered operand-B stage: builds the ALU's second operand from the register value,
// the PC increment or an extended immediate, and holds it behind a valid/ready register.
module alu_operand_b_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned PC_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SEL_W-1:0] SELECT,
  input  logic [WIDTH-1:0] B,
  input  logic [IMM_W-1:0] IMM_RAW,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SAIDA,
  output logic             ERR_SEL
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             err_sel_q, err_sel_d;

  logic [WIDTH-1:0] sext, zext, operand;
  logic [31:0]      upper_imm;
  logic             sel_illegal;
  logic             accept;

  assign sext      = WIDTH'($signed(IMM_RAW));
  assign zext      = WIDTH'(IMM_RAW);
  assign upper_imm = {IMM_RAW[19:0], 12'b0};

  always_comb begin
    operand     = '0;
    sel_illegal = 1'b0;
    case (SELECT)
      SEL_W'(0): operand = B;
      SEL_W'(1): operand = WIDTH'(PC_INC);
      SEL_W'(2): operand = sext;
      SEL_W'(3): operand = sext << 1;
      SEL_W'(4): operand = zext;
      SEL_W'(5): operand = WIDTH'($signed(upper_imm));
      default:   sel_illegal = 1'b1;
    endcase
  end

  // Ready depends only on the output side so upstream never sees a valid->ready loop.
  assign IN_READY = !out_valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    out_valid_d = out_valid_q;
    saida_d     = saida_q;
    err_sel_d   = err_sel_q;
    if (FLUSH) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      saida_d     = operand;
      if (sel_illegal) begin
        err_sel_d = 1'b1;
      end
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      saida_q     <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      saida_q     <= saida_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign SAIDA     = saida_q;
  assign ERR_SEL   = err_sel_q;

endmodule

// File: tb/tb_alu_operand_b_pipe.sv
// Directed bench for alu_operand_b_pipe with hand-computed expected operands.
module tb_alu_operand_b_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [2:0]  SELECT;
  logic [63:0] B;
  logic [31:0] IMM_RAW;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] SAIDA;
  logic        ERR_SEL;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_b_pipe #(
    .WIDTH (64),
    .IMM_W (32),
    .SEL_W (3),
    .PC_INC(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .FLUSH    (FLUSH),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .SELECT   (SELECT),
    .B        (B),
    .IMM_RAW  (IMM_RAW),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SAIDA    (SAIDA),
    .ERR_SEL  (ERR_SEL)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    FLUSH     = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    SELECT    = 3'd0;
    B         = 64'd0;
    IMM_RAW   = 32'd0;
    #1;
    check_eq("rst_valid", OUT_VALID, 0);
    check_eq("rst_saida", SAIDA, 0);
    check_eq("rst_err", ERR_SEL, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", IN_READY, 1);

    // PC increment, then asynchronous reset while holding
    IN_VALID  = 1'b1;
    SELECT    = 3'd1;
    OUT_READY = 1'b1;
    step();
    check_eq("pcinc_valid", OUT_VALID, 1);
    check_eq("pcinc_saida", SAIDA, 64'h0000_0000_0000_0004);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    step();
    check_eq("hold_valid", OUT_VALID, 1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", OUT_VALID, 0);
    check_eq("async_rst_saida", SAIDA, 0);
    reset = 1'b0;
    #1;

    // Immediate extensions back to back
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IMM_RAW   = 32'hFFFF_FFF0;
    SELECT    = 3'd2;
    step();
    check_eq("sext", SAIDA, 64'hFFFF_FFFF_FFFF_FFF0);
    SELECT = 3'd3;
    step();
    check_eq("sext_shl", SAIDA, 64'hFFFF_FFFF_FFFF_FFE0);
    check_eq("sext_shl_valid", OUT_VALID, 1);
    SELECT = 3'd4;
    step();
    check_eq("zext", SAIDA, 64'h0000_0000_FFFF_FFF0);
    check_eq("zext_valid", OUT_VALID, 1);

    SELECT  = 3'd5;
    IMM_RAW = 32'h000A_BCDE;
    step();
    check_eq("upper_neg", SAIDA, 64'hFFFF_FFFF_ABCD_E000);
    IMM_RAW = 32'h0001_2345;
    step();
    check_eq("upper_pos", SAIDA, 64'h0000_0000_1234_5000);

    // Stall
    SELECT = 3'd0;
    B      = 64'h1234;
    step();
    check_eq("stall_first", SAIDA, 64'h1234);
    OUT_READY = 1'b0;
    B         = 64'h5678;
    #1;
    check_eq("stall_in_ready", IN_READY, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_saida", SAIDA, 64'h1234);
      check_eq("stall_ready", IN_READY, 0);
      check_eq("stall_valid", OUT_VALID, 1);
    end
    OUT_READY = 1'b1;
    #1;
    check_eq("unstall_ready", IN_READY, 1);
    step();
    check_eq("unstall_saida", SAIDA, 64'h5678);
    check_eq("unstall_valid", OUT_VALID, 1);

    // Flush drops a same-cycle accept
    B = 64'h1234;
    step();
    check_eq("pre_flush_saida", SAIDA, 64'h1234);
    FLUSH = 1'b1;
    B     = 64'h9999;
    #1;
    check_eq("flush_in_ready", IN_READY, 1);
    step();
    check_eq("flush_valid", OUT_VALID, 0);
    check_eq("flush_saida", SAIDA, 64'h1234);
    FLUSH = 1'b0;

    // Illegal select is sticky
    SELECT = 3'd7;
    step();
    check_eq("illegal_saida", SAIDA, 0);
    check_eq("illegal_valid", OUT_VALID, 1);
    check_eq("illegal_err", ERR_SEL, 1);
    SELECT = 3'd0;
    B      = 64'hAAAA;
    step();
    check_eq("legal_after_saida", SAIDA, 64'hAAAA);
    check_eq("legal_after_err", ERR_SEL, 1);
    IN_VALID = 1'b0;
    step();
    check_eq("consume_valid", OUT_VALID, 0);
    check_eq("consume_saida", SAIDA, 64'hAAAA);
    check_eq("consume_err", ERR_SEL, 1);

    // Flushed illegal select must not set the flag
    reset = 1'b1;
    #1;
    check_eq("rst2_err", ERR_SEL, 0);
    reset    = 1'b0;
    SELECT   = 3'd6;
    IN_VALID = 1'b1;
    FLUSH    = 1'b1;
    step();
    check_eq("flush_illegal_err", ERR_SEL, 0);
    check_eq("flush_illegal_valid", OUT_VALID, 0);
    FLUSH = 1'b0;
    step();
    check_eq("illegal6_err", ERR_SEL, 1);
    check_eq("illegal6_saida", SAIDA, 0);
    IN_VALID = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
